serial_add_sub: RTL

Bit-serial, parametrised adder/subtractor. It is the sequential successor to the team's NOR-built half/full adders. A single NOR-only full-adder cell is reused over WIDTH clock cycles, processing LSB first, with a carry flip-flop between bits. A start/busy/done handshake lets a controller or testbench launch one operation at a time.

---
 rtl/serial_add_sub_pkg.sv | 15 +
 rtl/fa_from_nor.sv | 26 ++
 rtl/serial_add_sub.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_from_nor.sv
// One-bit full adder built only from two-input NOR gates (nine gates).
module fa_from_nor (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic n1, n2, n3, x_ab;
    logic m1, m2, m3;

    assign n1   = ~(a | b);
    assign n2   = ~(a | n1);
    assign n3   = ~(b | n1);
    assign x_ab = ~(n2 | n3);       // a XNOR b

    assign m1   = ~(x_ab | cin);    // (a ^ b) & ~cin
    assign m2   = ~(x_ab | m1);
    assign m3   = ~(cin | m1);
    assign sum  = ~(m2 | m3);

    // carry is low only when both operands are 0, or exactly one is 1 with no carry in
    assign cout = ~(n1 | m1);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one NOR full-adder cell reused LSB first over WIDTH cycles.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic             msb_cin_q, msb_cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic fa_s, fa_co;

    fa_from_nor u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (cin_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cin_d     = cin_q;
        msb_cin_d = msb_cin_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = (sub == OP_SUB) ? ~b : b;
                    cin_d   = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d          = acc_q >> 1;
                acc_d[WIDTH-1] = fa_s;
                opa_d          = opa_q >> 1;
                opb_d          = opb_q >> 1;
                cin_d          = fa_co;
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    msb_cin_d = cin_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                sum_d   = acc_q;
                carry_d = cin_q;
                ovf_d   = msb_cin_q ^ cin_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            cin_q     <= 1'b0;
            msb_cin_q <= 1'b0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cin_q     <= cin_d;
            msb_cin_q <= msb_cin_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule
